// File: rtl/vga_rx_timing.sv
// vga_rx_timing: recovers 800x600 VGA timing from sampled HS/VS/RGB444 and emits active-area pixels once locked.
// Define VGA_RX_MEASURE_EN to add the oLineLen/oFrameLines measurement ports.
module vga_rx_timing #(
  parameter int C_H_SYNC_PULSE  = 128,
  parameter int C_H_BACK_PORCH  = 88,
  parameter int C_H_ACTIVE_TIME = 800,
  parameter int C_H_FRONT_PORCH = 40,
  parameter int C_V_SYNC_PULSE  = 4,
  parameter int C_V_BACK_PORCH  = 23,
  parameter int C_V_ACTIVE_TIME = 600,
  parameter int C_V_FRONT_PORCH = 1,
  parameter int C_LOCK_FRAMES   = 2
) (
  input  logic        clkVga,
  input  logic        iRstN,
  input  logic        iHs,
  input  logic        iVs,
  input  logic [3:0]  iRed,
  input  logic [3:0]  iGreen,
  input  logic [3:0]  iBlue,
  output logic        oPixValid,
  output logic [9:0]  oPixX,
  output logic [9:0]  oPixY,
  output logic [11:0] oPixData,
  output logic        oFrameStart,
  output logic        oLocked,
  output logic        oSyncErr
`ifdef VGA_RX_MEASURE_EN
  ,
  output logic [10:0] oLineLen,
  output logic [10:0] oFrameLines
`endif
);
  localparam int C_H_TOTAL = C_H_SYNC_PULSE + C_H_BACK_PORCH + C_H_ACTIVE_TIME + C_H_FRONT_PORCH;
  localparam int C_V_TOTAL = C_V_SYNC_PULSE + C_V_BACK_PORCH + C_V_ACTIVE_TIME + C_V_FRONT_PORCH;
  localparam int GW = $clog2(C_LOCK_FRAMES + 1);
  localparam logic [10:0] H_END   = 11'(C_H_TOTAL - 1);
  localparam logic [10:0] V_END   = 11'(C_V_TOTAL - 1);
  localparam logic [10:0] H_FIRST = 11'(C_H_SYNC_PULSE + C_H_BACK_PORCH);
  localparam logic [10:0] H_LAST  = 11'(C_H_SYNC_PULSE + C_H_BACK_PORCH + C_H_ACTIVE_TIME - 1);
  localparam logic [10:0] V_FIRST = 11'(C_V_SYNC_PULSE + C_V_BACK_PORCH);
  localparam logic [10:0] V_LAST  = 11'(C_V_SYNC_PULSE + C_V_BACK_PORCH + C_V_ACTIVE_TIME - 1);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;
  state_t state_q, state_d;

  logic        s1_hs_q, s1_vs_q, s2_hs_q, s2_vs_q;
  logic [11:0] s1_rgb_q;
  logic [10:0] h_cnt_q, h_cnt_d, v_line_q, v_line_d;
  logic        vpend_q, vpend_d, line_bad_q, line_bad_d, armed_q, armed_d;
  logic [GW-1:0] good_q, good_d;
  logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d, sync_err_q, sync_err_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [11:0] pix_data_q, pix_data_d;
  logic        hs_fall, vs_fall, v_rst, line_err, frame_ok, lock_err, act;

  // armed_q skips the length check on the first HS fall after reset or loss of lock
  always_comb begin
    hs_fall    = s2_hs_q & ~s1_hs_q;
    vs_fall    = s2_vs_q & ~s1_vs_q;
    v_rst      = hs_fall & (vpend_q | vs_fall);
    line_err   = hs_fall & armed_q & (h_cnt_q != H_END);
    frame_ok   = (v_line_q == V_END) & ~line_bad_q & ~line_err;
    lock_err   = (state_q == LOCKED) & (line_err | (v_rst & ~frame_ok));
    h_cnt_d    = hs_fall ? '0 : (&h_cnt_q) ? h_cnt_q : h_cnt_q + 11'd1;
    v_line_d   = v_rst ? '0 : (hs_fall & ~&v_line_q) ? v_line_q + 11'd1 : v_line_q;
    vpend_d    = ~hs_fall & (vs_fall | vpend_q);
    line_bad_d = ~v_rst & (line_err | line_bad_q);
    armed_d    = ~lock_err & (hs_fall | armed_q);
  end

  always_ff @(posedge clkVga or negedge iRstN)
    if (!iRstN) state_q <= SEARCH;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (state_q == SEARCH && v_rst) begin
      state_d = ALIGN;
      good_d  = '0;
    end else if (state_q == ALIGN && v_rst) begin
      good_d = frame_ok ? good_q + GW'(1) : '0;
      if (frame_ok && int'(good_q) + 1 >= C_LOCK_FRAMES) state_d = LOCKED;
    end else if (lock_err) begin
      state_d = SEARCH;
    end
  end

  // outputs look at next-state counters so pins reach the outputs after two edges
  always_comb begin
    act           = (state_d == LOCKED) && h_cnt_d >= H_FIRST && h_cnt_d <= H_LAST &&
                    v_line_d >= V_FIRST && v_line_d <= V_LAST;
    pix_valid_d   = act;
    pix_x_d       = act ? 10'(h_cnt_d - H_FIRST) : pix_x_q;
    pix_y_d       = act ? 10'(v_line_d - V_FIRST) : pix_y_q;
    pix_data_d    = act ? s1_rgb_q : pix_data_q;
    frame_start_d = act & (h_cnt_d == H_FIRST) & (v_line_d == V_FIRST);
    sync_err_d    = lock_err;
  end

  always_ff @(posedge clkVga or negedge iRstN)
    if (!iRstN) begin
      {s1_hs_q, s1_vs_q, s2_hs_q, s2_vs_q} <= '0;
      s1_rgb_q      <= '0;
      h_cnt_q       <= '0;
      v_line_q      <= '0;
      vpend_q       <= 1'b0;
      line_bad_q    <= 1'b0;
      armed_q       <= 1'b0;
      good_q        <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_data_q    <= '0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      {s1_hs_q, s1_vs_q} <= {iHs, iVs};
      {s2_hs_q, s2_vs_q} <= {s1_hs_q, s1_vs_q};
      s1_rgb_q      <= {iBlue, iGreen, iRed};
      h_cnt_q       <= h_cnt_d;
      v_line_q      <= v_line_d;
      vpend_q       <= vpend_d;
      line_bad_q    <= line_bad_d;
      armed_q       <= armed_d;
      good_q        <= good_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_data_q    <= pix_data_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end

  assign oPixValid   = pix_valid_q;
  assign oPixX       = pix_x_q;
  assign oPixY       = pix_y_q;
  assign oPixData    = pix_data_q;
  assign oFrameStart = frame_start_q;
  assign oSyncErr    = sync_err_q;
  assign oLocked     = state_q == LOCKED;

`ifdef VGA_RX_MEASURE_EN
  logic        h_seen_q, v_seen_q;
  logic [10:0] line_len_q, frame_lines_q;

  always_ff @(posedge clkVga or negedge iRstN)
    if (!iRstN) begin
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
    end else begin
      h_seen_q <= h_seen_q | hs_fall;
      v_seen_q <= v_seen_q | v_rst;
      if (hs_fall && h_seen_q) line_len_q <= (&h_cnt_q) ? h_cnt_q : h_cnt_q + 11'd1;
      if (v_rst && v_seen_q) frame_lines_q <= (&v_line_q) ? v_line_q : v_line_q + 11'd1;
    end

  assign oLineLen    = line_len_q;
  assign oFrameLines = frame_lines_q;
`endif
endmodule

// File: tb/tb_vga_rx_timing.sv
// tb_vga_rx_timing: directed bench for vga_rx_timing using a scaled-down 17x9 raster.
module tb_vga_rx_timing;
  localparam int HS = 4, HB = 3, HA = 8, HF = 2, HT = HS + HB + HA + HF;
  localparam int VS = 2, VB = 2, VA = 4, VF = 1, VT = VS + VB + VA + VF;

  logic        clkVga = 1'b0, iRstN = 1'b1, iHs = 1'b1, iVs = 1'b1;
  logic [3:0]  iRed = '0, iGreen = '0, iBlue = '0;
  logic        oPixValid, oFrameStart, oLocked, oSyncErr;
  logic [9:0]  oPixX, oPixY;
  logic [11:0] oPixData;
  logic [35:0] outs;
`ifdef VGA_RX_MEASURE_EN
  logic [10:0] oLineLen, oFrameLines;
`endif

  int n_chk = 0, n_fail = 0, cyc = 0, line_cyc = 0, frm_cyc = 0, bad_cyc = 0;
  int lock_cyc = -1, unl_cyc = -1, err_cyc = -1, err_cnt = 0, vld_cnt = 0, fs_cnt = 0, idx = 0, v0 = 0;
  logic [11:0] p1 = '0, p2 = '0;
  logic lk_prev = 1'b0;

  vga_rx_timing #(
    .C_H_SYNC_PULSE(HS), .C_H_BACK_PORCH(HB), .C_H_ACTIVE_TIME(HA), .C_H_FRONT_PORCH(HF),
    .C_V_SYNC_PULSE(VS), .C_V_BACK_PORCH(VB), .C_V_ACTIVE_TIME(VA), .C_V_FRONT_PORCH(VF),
    .C_LOCK_FRAMES(2)
  ) u_dut (
    .clkVga(clkVga), .iRstN(iRstN), .iHs(iHs), .iVs(iVs),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .oPixValid(oPixValid), .oPixX(oPixX), .oPixY(oPixY), .oPixData(oPixData),
    .oFrameStart(oFrameStart), .oLocked(oLocked), .oSyncErr(oSyncErr)
`ifdef VGA_RX_MEASURE_EN
    , .oLineLen(oLineLen), .oFrameLines(oFrameLines)
`endif
  );

  assign outs = {oPixValid, oPixX, oPixY, oPixData, oFrameStart, oLocked, oSyncErr};

  always #5 clkVga = ~clkVga;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // pins seen at each edge; p2 is what the outputs must carry after the following edge
  always @(posedge clkVga) begin
    cyc++;
    p2 = p1;
    p1 = {iBlue, iGreen, iRed};
  end

  always @(negedge clkVga) begin
    if (oLocked && !lk_prev) lock_cyc = cyc;
    if (!oLocked && lk_prev) unl_cyc = cyc;
    lk_prev = oLocked;
    if (oSyncErr) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (oFrameStart) begin
      fs_cnt++;
      idx = 0;
    end
    if (oPixValid) begin
      vld_cnt++;
      check("pix_x", oPixX, idx % HA);
      check("pix_y", oPixY, idx / HA);
      check("pix_rgb", oPixData, {4'h5, 4'(idx / HA), 4'(idx % HA)});
      check("pix_lat", oPixData, p2);
      check("pix_lock", oLocked, 1);
      idx++;
    end
  end

  task automatic drive_line(input int ln, input int len);
    logic a;
    for (int h = 0; h < len; h++) begin
      @(posedge clkVga);
      #1;
      if (h == 0) line_cyc = cyc;
      if (h == 0 && ln == 0) frm_cyc = cyc;
      a = h >= HS + HB && h < HS + HB + HA && ln >= VS + VB && ln < VS + VB + VA;
      iHs    = h >= HS;
      iVs    = ln >= VS;
      iRed   = a ? 4'(h - HS - HB) : 4'h0;
      iGreen = a ? 4'(ln - VS - VB) : 4'h0;
      iBlue  = a ? 4'h5 : 4'h0;
    end
  endtask

  task automatic drive_frame(input int nl);
    for (int l = 0; l < nl; l++) drive_line(l, HT);
  endtask

  task automatic idle(input int n);
    iHs = 1'b1;
    iVs = 1'b1;
    {iRed, iGreen, iBlue} = '0;
    repeat (n) @(posedge clkVga);
    #1;
  endtask

  initial begin
    #2 iRstN = 1'b0;
    repeat (3) @(posedge clkVga);
    #1;
    check("rst_outs", outs, 0);
    iRstN = 1'b1;
    idle(3);
    drive_frame(VT);
    drive_frame(VT);
    check("pre_lock", oLocked, 0);
    check("pre_vld", vld_cnt, 0);
    drive_frame(VT);
    check("lock_cyc", lock_cyc, frm_cyc + 2);
    check("f3_vld", vld_cnt, HA * VA);
    check("f3_fs", fs_cnt, 1);
    v0 = vld_cnt;
    drive_frame(VT);
    check("f4_vld", vld_cnt - v0, HA * VA);
    check("f4_fs", fs_cnt, 2);
    check("f4_lock", oLocked, 1);
    check("f4_err", err_cnt, 0);
`ifdef VGA_RX_MEASURE_EN
    check("line_len", oLineLen, HT);
    check("frame_lines", oFrameLines, VT);
`endif
    // line 5 one clock short: error reported at the HS fall opening line 6
    v0 = vld_cnt;
    for (int l = 0; l < VT; l++) begin
      drive_line(l, l == 5 ? HT - 1 : HT);
      if (l == 6) begin
        bad_cyc = line_cyc;
`ifdef VGA_RX_MEASURE_EN
        check("line_len_short", oLineLen, HT - 1);
`endif
      end
    end
    check("err_cyc", err_cyc, bad_cyc + 2);
    check("unlock_cyc", unl_cyc, bad_cyc + 2);
    check("err_cnt", err_cnt, 1);
    check("err_unlock", oLocked, 0);
    check("f5_vld", vld_cnt - v0, 2 * HA);
    v0 = vld_cnt;
    drive_frame(VT);
    drive_frame(VT);
    check("relock_vld", vld_cnt - v0, 0);
    check("relock_pre", oLocked, 0);
    drive_frame(VT);
    check("relock_cyc", lock_cyc, frm_cyc + 2);
    check("f8_vld", vld_cnt - v0, HA * VA);
    // reset asserted mid-line while locked
    for (int l = 0; l < 5; l++) drive_line(l, HT);
    drive_line(5, 12);
    check("pre_rst_lock", oLocked, 1);
    #2 iRstN = 1'b0;
    #1 check("rst_mid", outs, 0);
    repeat (2) @(posedge clkVga);
    #1 iRstN = 1'b1;
    idle(3);
    v0 = vld_cnt;
    // short frame while aligning delays lock by one frame without an error pulse
    drive_frame(VT - 1);
    drive_frame(VT);
    drive_frame(VT);
    check("align_bad_lock", oLocked, 0);
    check("align_bad_vld", vld_cnt - v0, 0);
    drive_frame(VT);
    check("align_lock_cyc", lock_cyc, frm_cyc + 2);
    check("align_err_cnt", err_cnt, 1);
    check("f13_vld", vld_cnt - v0, HA * VA);
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_rx_timing.md
# vga_rx_timing

Receive-side VGA timing recovery for the 800×600 display path: samples an incoming HS/VS/RGB444 stream on the pixel clock and locks onto its sync structure. It validates line and frame lengths and emits per-pixel coordinates and colour for active-area pixels only. It sits opposite the VGA timing generator and feeds capture logic and self-check benches.

## Interface
- C_H_SYNC_PULSE, 128, HS low width (clocks)
- C_H_BACK_PORCH, 88, clocks from HS rise to first active pixel
- C_H_ACTIVE_TIME, 800, active pixels per line
- C_H_FRONT_PORCH, 40; line total C_H_TOTAL = sum = 1056
- C_V_SYNC_PULSE, 4, VS low width (lines)
- C_V_BACK_PORCH, 23, lines from VS rise to first active line
- C_V_ACTIVE_TIME, 600, active lines
- C_V_FRONT_PORCH, 1; frame total C_V_TOTAL = sum = 628
- C_LOCK_FRAMES, 2, consecutive clean frames required to lock
- clkVga in 1 pixel clock, 40 MHz; all logic on rising edge
- iRstN in 1 reset, asynchronous, active-low
- iHs in 1 horizontal sync, active low
- iVs in 1 vertical sync, active low
- iRed, iGreen, iBlue in 4 each colour inputs
- oPixValid out 1 active pixel strobe
- oPixX out 10 active column 0..799
- oPixY out 10 active row 0..599
- oPixData out 12 {blue, green, red}
- oFrameStart out 1 one-cycle pulse with pixel (0,0)
- oLocked out 1 timing locked
- oSyncErr out 1 one-cycle pulse on timing violation while locked
- oLineLen, oFrameLines out 11 each (only with VGA_RX_MEASURE_EN)

## Operation
- Input stage: iHs, iVs, and RGB are registered together (stage s1); edges are detected s1 vs s2.
- hCnt is 11-bit and saturates at 2047. It is 0 on the cycle HS is first seen low (HS fall), and increments otherwise.
- vLine is 11-bit and saturates at 2047. A VS fall sets vPend. On each HS fall: if vPend, vLine←0 and vPend cleared; else vLine+1. A coincident VS and HS fall resets vLine on that HS fall.
- Active region:
  - hCnt in [216, 1015] (sync + back porch, 800 wide).
  - vLine in [27, 626].
  - oPixX = hCnt−216, oPixY = vLine−27.
- Line check at each HS fall, except the first after SEARCH: the previous hCnt must equal C_H_TOTAL−1; otherwise lineBad is set for the current frame.
- Frame check at each vLine reset: the previous vLine must equal C_V_TOTAL−1, and lineBad must be clear. lineBad is then cleared.
- State machine:
  - SEARCH: on first vLine reset, go to ALIGN with goodCnt=0.
  - ALIGN:
    - At each vLine reset, a clean frame increments goodCnt.
    - When goodCnt reaches C_LOCK_FRAMES, go to LOCKED.
    - A bad frame zeroes goodCnt and stays in ALIGN.
  - LOCKED:
    - Any line-length mismatch at HS fall, or frame mismatch at vLine reset, pulses oSyncErr for 1 cycle and goes to SEARCH.
    - oLocked drops on the same cycle.
- oPixValid=1 only in LOCKED and inside the active region. oPixX, oPixY, and oPixData are held when invalid.
- oFrameStart=1 iff oPixValid and X=0, Y=0.
- Reset values are 0 for every output, hCnt, vLine, goodCnt, vPend, and lineBad; state is SEARCH. Reset mid-frame aborts lock immediately.

## Timing
- Latency: a pin value sampled at edge n appears on outputs after edge n+1 (2 register stages).
- oLocked rises on the registered cycle of the vLine reset that completes the C_LOCK_FRAMES-th clean frame.
- With a conforming source, lock is reached at the 3rd vLine reset after reset release. The first valid pixel comes 27 lines plus 216 clocks later.
- oSyncErr and LOCKED exit occur on the output cycle corresponding to the offending HS fall. No pixel of the offending line after that point is valid.
- Per locked frame: exactly 480000 oPixValid cycles, 800 consecutive per line.

## Configuration
- VGA_RX_MEASURE_EN defined:
  - oLineLen captures previous hCnt+1 at each HS fall, after the first.
  - oFrameLines captures previous vLine+1 at each vLine reset, after the first.
  - Both are valid regardless of lock, and reset to 0.
- Undefined: both ports and their registers are absent. All other behaviour is identical.

## Test plan
- Reset asserted mid-stream → all outputs 0 within the same cycle, state SEARCH. After release, no oPixValid until re-lock.
- Conforming 1056×628 source for 4 frames → oLocked=1 at the 3rd vLine reset. Frame 4 shows oFrameStart once, 480000 valid pixels, X 0..799, Y 0..599. oPixData matches the driven colour 2 edges after the pins.
- While locked, one line of 1055 clocks → single-cycle oSyncErr, oLocked=0, no further oPixValid. Re-lock after 2 further clean frames.
- Frame of 627 lines during ALIGN → goodCnt resets, no oSyncErr, and lock is delayed by one frame.
- VS fall coincident with HS fall → vLine=0 on that line, correct Y alignment (first active row is the 28th line).
- VGA_RX_MEASURE_EN defined, conforming source → oLineLen=1056 and oFrameLines=628. With a 1060-clock line, oLineLen=1060 for that line.
